// File: rtl/div_link_pkg.sv
// Shared definitions for the divider byte-serial link: bridge FSM states,
// frame layout constants, default timing parameters and the tx byte mux.
package div_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PUSH,
        ST_GAP,
        ST_WAIT_RSP,
        ST_COLLECT,
        ST_RESP
    } state_e;

    localparam int LINK_BYTES = 8;
    localparam int IDX_W      = $clog2(LINK_BYTES);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(LINK_BYTES - 1);

    // Reply frame byte index holding the LSB of each result word.
    localparam int RX_REM_LSB = 0;
    localparam int RX_QUO_LSB = 4;

    localparam int DEF_PUSH_GAP = 4;
    localparam int DEF_TIMEOUT  = 1024;
    localparam int DEF_CNT_W    = 11;

    // Request bytes go out MSB first: dividend[31:24] .. dividend[7:0], then divisor likewise.
    function automatic logic [7:0] tx_byte(input logic [31:0] dividend,
                                           input logic [31:0] divisor,
                                           input logic [IDX_W-1:0] idx);
        logic [63:0] w_word;
        w_word = {dividend, divisor} << {idx, 3'b000};
        return w_word[63:56];
    endfunction

endpackage

// File: rtl/div_link_rx_collect.sv
// Reply-frame collector: assembles the 8 pull-framed reply bytes, restarting
// at byte 0 whenever a new pull marker arrives.
module div_link_rx_collect
    import div_link_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wait,
    input  logic                    i_collect,
    input  logic                    i_pull,
    input  logic                    i_sign_in,
    input  logic [7:0]              i_data,
    output logic                    o_done,
    output logic                    o_sign,
    output logic [8*LINK_BYTES-1:0] o_frame
);

    logic [8*LINK_BYTES-1:0] r_frame;
    logic [IDX_W-1:0]        r_rx_idx;
    logic                    r_sign;

    logic                    w_start;
    logic                    w_capture;
    logic [IDX_W-1:0]        w_idx;
    logic [8*LINK_BYTES-1:0] w_frame_next;

    assign w_start   = (i_wait | i_collect) & i_pull;
    assign w_capture = w_start | i_collect;
    assign w_idx     = w_start ? '0 : r_rx_idx;

    always_comb begin
        // NOTE: default-first assignment means every path writes every bit, so no latch is inferred.
        w_frame_next = r_frame;
        for (int k = 0; k < LINK_BYTES; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_frame_next[8*k +: 8] = i_data;
            end
        end
    end

    // The frame is complete in the cycle byte 7 arrives; the top consumes the unregistered view.
    assign o_done  = i_collect & ~i_pull & (r_rx_idx == LAST_BYTE);
    assign o_sign  = w_start ? i_sign_in : r_sign;
    assign o_frame = w_frame_next;

    // NOTE: the frame is plain flops rather than a RAM, so it takes the async reset like all other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame  <= '0;
            r_rx_idx <= '0;
            r_sign   <= 1'b0;
        end else if (w_capture) begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_frame  <= w_frame_next;
            r_rx_idx <= w_idx + 1'b1;
            if (w_start) begin
                r_sign <= i_sign_in;
            end
        end
    end

endmodule

// File: rtl/div_host_bridge.sv
// Host-side initiator for the divider byte link: serialises one divide request
// into 8 push-strobed bytes and returns the pull-framed reply on a valid/ready port.
module div_host_bridge
    import div_link_pkg::*;
#(
    parameter int PUSH_GAP = DEF_PUSH_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    input  logic        req_sign,
    input  logic        req_select,
    output logic [7:0]  data_out,
    output logic        push_out,
    output logic        sign_out,
    output logic        select_out,
    input  logic [7:0]  data_in,
    input  logic        pull_in,
    input  logic        sign_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_quotient,
    output logic [31:0] rsp_remainder,
    output logic        rsp_sign,
    output logic        rsp_timeout
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(PUSH_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [IDX_W-1:0]        r_byte_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [31:0]             r_dividend;
    logic [31:0]             r_divisor;
    logic                    r_sign;
    logic                    r_select;
    logic [31:0]             r_rsp_quo;
    logic [31:0]             r_rsp_rem;
    logic                    r_rsp_sign;
    logic                    r_rsp_timeout;

    logic                    w_in_wait;
    logic                    w_in_collect;
    logic                    w_rx_done;
    logic                    w_rx_sign;
    logic [8*LINK_BYTES-1:0] w_rx_frame;

    assign w_in_wait    = (r_state == ST_WAIT_RSP);
    assign w_in_collect = (r_state == ST_COLLECT);

    div_link_rx_collect u_rx_collect (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wait    (w_in_wait),
        .i_collect (w_in_collect),
        .i_pull    (pull_in),
        .i_sign_in (sign_in),
        .i_data    (data_in),
        .o_done    (w_rx_done),
        .o_sign    (w_rx_sign),
        .o_frame   (w_rx_frame)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        push_out  = 1'b0;
        rsp_valid = 1'b0;
        data_out  = 8'h00;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                data_out = tx_byte(r_dividend, r_divisor, r_byte_idx);
                w_next   = ST_PUSH;
            end
            ST_PUSH: begin
                data_out = tx_byte(r_dividend, r_divisor, r_byte_idx);
                push_out = 1'b1;
                w_next   = ST_GAP;
            end
            ST_GAP: begin
                data_out = tx_byte(r_dividend, r_divisor, r_byte_idx);
                if (r_cnt == GAP_LAST) begin
                    w_next = (r_byte_idx == LAST_BYTE) ? ST_WAIT_RSP : ST_SETUP;
                end
            end
            ST_WAIT_RSP: begin
                // A pull marker on the final wait cycle still wins over the timeout.
                if (pull_in)                w_next = ST_COLLECT;
                else if (r_cnt == TO_LAST)  w_next = ST_RESP;
            end
            ST_COLLECT: begin
                if (w_rx_done) w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx    <= '0;
            r_cnt         <= '0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_sign        <= 1'b0;
            r_select      <= 1'b0;
            r_rsp_quo     <= '0;
            r_rsp_rem     <= '0;
            r_rsp_sign    <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_dividend <= req_dividend;
                r_divisor  <= req_divisor;
                r_sign     <= req_sign;
                r_select   <= req_select;
                r_byte_idx <= '0;
            end else if (r_state == ST_GAP && w_next == ST_SETUP) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end

            // One counter times both the inter-byte gap and the reply wait; it clears on every state change.
            if ((r_state == ST_GAP || r_state == ST_WAIT_RSP) && w_next == r_state) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == ST_WAIT_RSP && w_next == ST_RESP) begin
                r_rsp_quo     <= '0;
                r_rsp_rem     <= '0;
                r_rsp_sign    <= 1'b0;
                r_rsp_timeout <= 1'b1;
            end else if (r_state == ST_COLLECT && w_next == ST_RESP) begin
                r_rsp_quo     <= w_rx_frame[8*RX_QUO_LSB +: 32];
                r_rsp_rem     <= w_rx_frame[8*RX_REM_LSB +: 32];
                r_rsp_sign    <= w_rx_sign;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign sign_out      = r_sign;
    assign select_out    = r_select;
    assign rsp_quotient  = r_rsp_quo;
    assign rsp_remainder = r_rsp_rem;
    assign rsp_sign      = r_rsp_sign;
    assign rsp_timeout   = r_rsp_timeout;

endmodule

// File: tb/tb_div_host_bridge.sv
// Bench for div_host_bridge: an emulated divider answers on the byte link and a
// scoreboard checks every response against a sign-magnitude reference divider.
`timescale 1ns/1ps
module tb_div_host_bridge;

    localparam int PUSH_GAP = 2;
    localparam int TIMEOUT  = 40;
    localparam int CNT_W    = 11;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_SILENT  = 1;
    localparam int MODE_RESTART = 2;

    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        sign;
        logic        timeout;
    } rsp_t;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] d;
        logic        sign;
        logic        sel;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_dividend, req_divisor;
    logic        req_sign, req_select;
    logic [7:0]  data_out;
    logic        push_out, sign_out, select_out;
    logic [7:0]  data_in;
    logic        pull_in, sign_in;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic        rsp_sign, rsp_timeout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_push_cyc = 0;
    int   push_total = 0;
    req_t cur_req;
    int   cur_mode = MODE_NORMAL;
    int   cur_delay = PUSH_GAP + 1;
    rsp_t exp_q[$];
    logic prev_valid = 1'b0;

    div_host_bridge #(.PUSH_GAP(PUSH_GAP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_sign      (req_sign),
        .req_select    (req_select),
        .data_out      (data_out),
        .push_out      (push_out),
        .sign_out      (sign_out),
        .select_out    (select_out),
        .data_in       (data_in),
        .pull_in       (pull_in),
        .sign_in       (sign_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_sign      (rsp_sign),
        .rsp_timeout   (rsp_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference divider: unsigned, or sign-magnitude with quotient sign z^d and remainder sign of z.
    function automatic rsp_t golden(input logic [31:0] z, input logic [31:0] d, input logic s);
        rsp_t        r;
        logic [30:0] zm, dm;
        r.timeout = 1'b0;
        if (!s) begin
            r.quo  = z / d;
            r.rem  = z % d;
            r.sign = 1'b0;
        end else begin
            zm     = z[30:0];
            dm     = d[30:0];
            r.quo  = {z[31] ^ d[31], zm / dm};
            r.rem  = {z[31], zm % dm};
            r.sign = z[31] ^ d[31];
        end
        return r;
    endfunction

    // Emulated divider: gathers the 8 pushed bytes, then answers with a pull-framed reply.
    initial begin : divider_emu
        int          nrx;
        int          side_err;
        int          gap_err;
        logic [63:0] rx_word;
        logic [63:0] rw;
        rsp_t        r;
        nrx = 0; side_err = 0; gap_err = 0; rx_word = '0;
        pull_in = 1'b0; data_in = 8'h00; sign_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrx = 0;
            end else if (push_out === 1'b1) begin
                push_total++;
                if (nrx == 0) begin
                    side_err = 0; gap_err = 0; rx_word = '0;
                end else if (cyc - last_push_cyc != 2 + PUSH_GAP) begin
                    gap_err++;
                end
                if (sign_out !== cur_req.sign || select_out !== cur_req.sel) side_err++;
                last_push_cyc = cyc;
                rx_word = {rx_word[55:0], data_out};
                nrx++;
                if (nrx == 8) begin
                    nrx = 0;
                    check("tx_frame", rx_word, {cur_req.z, cur_req.d});
                    check("push_spacing", gap_err, 0);
                    check("sign_select_hold", side_err, 0);
                    if (cur_mode != MODE_SILENT) begin
                        r  = golden(rx_word[63:32], rx_word[31:0], sign_out);
                        rw = {r.quo, r.rem};
                        repeat (cur_delay) @(negedge clk);
                        if (cur_mode == MODE_RESTART) begin
                            for (int i = 0; i < 3; i++) begin
                                data_in = ~rw[8*i +: 8]; pull_in = (i == 0); sign_in = ~r.sign;
                                @(negedge clk);
                            end
                        end
                        for (int i = 0; i < 8; i++) begin
                            data_in = rw[8*i +: 8]; pull_in = (i == 0); sign_in = r.sign;
                            @(negedge clk);
                        end
                        pull_in = 1'b0; data_in = 8'h00; sign_in = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: compares each new response against the oldest expectation.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got quo 0x%0h with no pending request", rsp_quotient);
            end else begin
                e = exp_q.pop_front();
                check("rsp_quotient", rsp_quotient, e.quo);
                check("rsp_remainder", rsp_remainder, e.rem);
                check("rsp_sign", rsp_sign, e.sign);
                check("rsp_timeout", rsp_timeout, e.timeout);
                if (e.timeout) check("timeout_latency", cyc - last_push_cyc, PUSH_GAP + TIMEOUT + 1);
            end
        end
        prev_valid <= rsp_valid;
    end

    task automatic do_req(input req_t rq, input int mode, input int delay, input rsp_t exp, input int hold);
        int n;
        int hold_err;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL req_ready_wait: got req_ready=%b expected 1 within 200 cycles", req_ready);
            return;
        end
        cur_req = rq; cur_mode = mode; cur_delay = delay;
        exp_q.push_back(exp);
        req_valid = 1'b1; req_dividend = rq.z; req_divisor = rq.d;
        req_sign = rq.sign; req_select = rq.sel;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (rsp_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL rsp_wait: got rsp_valid=%b expected 1 within 400 cycles", rsp_valid);
            exp_q.delete();
            return;
        end
        hold_err = 0;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_quotient !== exp.quo ||
                rsp_remainder !== exp.rem || rsp_sign !== exp.sign || rsp_timeout !== exp.timeout)
                hold_err++;
            @(negedge clk);
        end
        if (hold >= 20) check("backpressure_hold", hold_err, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_release", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        req_t rq;
        rsp_t ex;
        int   seen;
        int   n;
        int   mode;
        int   p0;
        req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_sign = 1'b0; req_select = 1'b0; rsp_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_tx", {push_out, data_out, sign_out, select_out}, '0);
        check("reset_rsp", {rsp_valid, rsp_quotient, rsp_remainder, rsp_sign, rsp_timeout}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned 100 / 7.
        rq = '{z: 32'd100, d: 32'd7, sign: 1'b0, sel: 1'b0};
        do_req(rq, MODE_NORMAL, PUSH_GAP + 3, '{quo: 32'd14, rem: 32'd2, sign: 1'b0, timeout: 1'b0}, 0);

        // Signed sign-magnitude -100 / 7.
        rq = '{z: 32'h8000_0064, d: 32'd7, sign: 1'b1, sel: 1'b0};
        do_req(rq, MODE_NORMAL, PUSH_GAP + 1,
               '{quo: 32'h8000_000E, rem: 32'h8000_0002, sign: 1'b1, timeout: 1'b0}, 2);

        // Divider never answers.
        rq = '{z: 32'd50, d: 32'd5, sign: 1'b0, sel: 1'b1};
        do_req(rq, MODE_SILENT, 0, '{quo: 32'd0, rem: 32'd0, sign: 1'b0, timeout: 1'b1}, 1);

        // Aborted reply frame followed by a clean one.
        rq = '{z: 32'h1234_5678, d: 32'h0000_1234, sign: 1'b0, sel: 1'b1};
        do_req(rq, MODE_RESTART, PUSH_GAP + 2,
               '{quo: 32'h0001_0004, rem: 32'h0000_0DA8, sign: 1'b0, timeout: 1'b0}, 0);

        // Response held under 20 cycles of backpressure.
        rq = '{z: 32'd1000, d: 32'd33, sign: 1'b0, sel: 1'b1};
        do_req(rq, MODE_NORMAL, PUSH_GAP + 4, '{quo: 32'd30, rem: 32'd10, sign: 1'b0, timeout: 1'b0}, 20);

        // Reset in the middle of the send phase.
        rq = '{z: 32'h8765_4321, d: 32'h8000_0003, sign: 1'b1, sel: 1'b1};
        cur_req = rq; cur_mode = MODE_NORMAL; cur_delay = PUSH_GAP + 1;
        req_valid = 1'b1; req_dividend = rq.z; req_divisor = rq.d;
        req_sign = rq.sign; req_select = rq.sel;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0; n = 0;
        while (seen < 3 && n < 200) begin
            @(negedge clk); n++;
            if (push_out === 1'b1) seen++;
        end
        check("reset_reached_push", seen, 3);
        rst_n = 1'b0;
        #1;
        check("midreset_push_out", push_out, 1'b0);
        check("midreset_req_ready", req_ready, 1'b1);
        check("midreset_tx", {data_out, sign_out, select_out}, '0);
        check("midreset_rsp", {rsp_valid, rsp_quotient, rsp_remainder, rsp_sign, rsp_timeout}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rq = '{z: 32'd7, d: 32'd100, sign: 1'b0, sel: 1'b0};
        do_req(rq, MODE_NORMAL, PUSH_GAP + 1, '{quo: 32'd0, rem: 32'd7, sign: 1'b0, timeout: 1'b0}, 0);

        // Randomised requests against the reference divider.
        p0 = push_total;
        for (int k = 0; k < 80; k++) begin
            rq.z    = $urandom;
            rq.d    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 5000)) : $urandom;
            rq.sign = ($urandom_range(0, 1) == 1);
            rq.sel  = ($urandom_range(0, 1) == 1);
            if (rq.sign) rq.d[31] = ($urandom_range(0, 1) == 1);
            if (rq.d[30:0] == 31'd0) rq.d[0] = 1'b1;
            n = int'($urandom_range(0, 9));
            mode = (n == 0) ? MODE_RESTART : (n == 1) ? MODE_SILENT : MODE_NORMAL;
            if (mode == MODE_SILENT) ex = '{quo: 32'd0, rem: 32'd0, sign: 1'b0, timeout: 1'b1};
            else                     ex = golden(rq.z, rq.d, rq.sign);
            do_req(rq, mode, PUSH_GAP + 1 + int'($urandom_range(0, 6)), ex, int'($urandom_range(0, 3)));
        end
        check("push_count", push_total - p0, 8 * 80);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
